// File: rtl/usb_attach_ctrl.sv
// USB D+/D- attach/detach controller: timed soft-disconnect, run-time speed swap, bus-reset/suspend detect.
// Inputs reach core_d_i/line_state after SYNC_STAGES cycles; output pin path is combinational, no backpressure.
module usb_attach_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int DISC_CYCLES        = 480000,
  parameter int RESET_CYCLES       = 120,
  parameter int SUSPEND_CYCLES     = 144000,
  parameter bit DEFAULT_FULL_SPEED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_connect,
  input  logic       full_speed,
  input  logic [1:0] pin_d_i,
  output logic [1:0] pin_d_o,
  output logic       pin_d_oe,
  output logic       pullup_en,
  output logic [1:0] core_d_i,
  input  logic [1:0] core_d_o,
  input  logic       core_d_en,
  output logic       core_reset,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       suspended,
  output logic       mode_fs,
  output logic [1:0] state
);

  localparam int HOLD_W = $clog2(DISC_CYCLES + 1);
  localparam int SE0_W  = $clog2(RESET_CYCLES + 1);
  localparam int J_W    = $clog2(SUSPEND_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'b00,
    ST_DETACHED  = 2'b01,
    ST_ATTACHED  = 2'b10,
    ST_SUSPENDED = 2'b11
  } state_t;

  state_t            cur_st, nxt_st;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [SE0_W-1:0]  se0_cnt, se0_nxt;
  logic [J_W-1:0]    j_cnt, j_nxt;
  logic              mode_nxt;
  logic [1:0]        sync_q [SYNC_STAGES];
  logic [1:0]        pins_s;
  logic              on_bus, count_ok, is_se0, is_j, is_k;

  // Raw pins are synchronised before the speed swap so the swap never sees metastable data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
    end else begin
      sync_q[0] <= pin_d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pins_s    = sync_q[SYNC_STAGES-1];
  assign core_d_i  = mode_fs ? pins_s : {pins_s[0], pins_s[1]};
  assign pin_d_o   = mode_fs ? core_d_o : {core_d_o[0], core_d_o[1]};
  assign on_bus    = (cur_st == ST_ATTACHED) || (cur_st == ST_SUSPENDED);
  assign pin_d_oe  = core_d_en & on_bus;
  assign pullup_en = on_bus;
  assign suspended = (cur_st == ST_SUSPENDED);
  assign core_reset = ~on_bus | bus_reset;
  assign state     = cur_st;

  always_comb begin
    line_state = 2'b10;
    if (core_d_i == 2'b00)
      line_state = 2'b00;
    else if (core_d_i == 2'b11)
      line_state = 2'b11;
    else if (core_d_i == (mode_fs ? 2'b10 : 2'b01))
      line_state = 2'b01;
  end

  assign is_se0 = (line_state == 2'b00);
  assign is_j   = (line_state == 2'b01);
  assign is_k   = (line_state == 2'b10);

  // Our own transmission (including EOP) must never look like idle or a host reset.
  assign count_ok = on_bus & soft_connect & ~pin_d_oe;

  always_comb begin
    se0_nxt = '0;
    j_nxt   = '0;
    if (count_ok && is_se0)
      se0_nxt = (se0_cnt == SE0_W'(RESET_CYCLES)) ? se0_cnt : se0_cnt + 1'b1;
    if (count_ok && is_j && cur_st == ST_ATTACHED)
      j_nxt = (j_cnt == J_W'(SUSPEND_CYCLES)) ? j_cnt : j_cnt + 1'b1;
  end

  always_comb begin
    nxt_st   = cur_st;
    hold_nxt = hold_cnt;
    mode_nxt = mode_fs;
    case (cur_st)
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(DISC_CYCLES - 1)) begin
          nxt_st   = ST_DETACHED;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_DETACHED: begin
        hold_nxt = '0;
        if (soft_connect) begin
          mode_nxt = full_speed;
          nxt_st   = ST_ATTACHED;
        end
      end
      ST_ATTACHED: begin
        if (!soft_connect) begin
          nxt_st   = ST_HOLD;
          hold_nxt = '0;
        end else if (j_nxt == J_W'(SUSPEND_CYCLES)) begin
          nxt_st = ST_SUSPENDED;
        end
      end
      ST_SUSPENDED: begin
        if (!soft_connect) begin
          nxt_st   = ST_HOLD;
          hold_nxt = '0;
        end else if (is_se0 || is_k) begin
          nxt_st = ST_ATTACHED;
        end
      end
      default: begin
        nxt_st   = ST_HOLD;
        hold_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st    <= ST_HOLD;
      hold_cnt  <= '0;
      mode_fs   <= DEFAULT_FULL_SPEED;
      se0_cnt   <= '0;
      j_cnt     <= '0;
      bus_reset <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      hold_cnt  <= hold_nxt;
      mode_fs   <= mode_nxt;
      se0_cnt   <= se0_nxt;
      j_cnt     <= j_nxt;
      bus_reset <= (se0_nxt == SE0_W'(RESET_CYCLES));
    end
  end

endmodule
